// File: rtl/alu_mc_responder_pkg.sv
// Shared opcodes, FSM encoding and opcode helpers for the multi-cycle ALU responder.
package alu_mc_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } alu_fsm_e;

    localparam int unsigned OpAdd = 32'h01;
    localparam int unsigned OpSub = 32'h02;
    localparam int unsigned OpMul = 32'h03;
    localparam int unsigned OpSrl = 32'h04;
    localparam int unsigned OpSll = 32'h05;
    localparam int unsigned OpAnd = 32'h06;
    localparam int unsigned OpOr  = 32'h07;
    localparam int unsigned OpNor = 32'h08;
    localparam int unsigned OpSlt = 32'h09;

    function automatic logic op_is_shift(input int unsigned op);
        return (op == OpSrl) || (op == OpSll);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, DATA_WIDTH clocks per product.
module alu_mul_iter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] mcand_i,
    input  logic [DATA_WIDTH-1:0] mplier_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o
);
    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2*DATA_WIDTH-1:0] acc_q, acc_d, step;
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH:0]     sum;

    // Upper half accumulates the partial product; lower half shifts the multiplier out.
    always_comb begin
        sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        step = {sum, acc_q[DATA_WIDTH-1:1]};
    end

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start_i) begin
            acc_d   = {{DATA_WIDTH{1'b0}}, mplier_i};
            mcand_d = mcand_i;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    // done_o flags the final step; product_o is the value that step produces.
    assign done_o    = busy_q && (cnt_q == CntW'(DATA_WIDTH - 1));
    assign product_o = step[DATA_WIDTH-1:0];

endmodule

// File: rtl/alu_mc_responder.sv
// Multi-cycle ALU responder: valid/ready request in, iterative mul/shift, valid/ready response out.
module alu_mc_responder
    import alu_mc_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [OPRN_WIDTH-1:0] oprn,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  rsp_err
);
    localparam int unsigned RemW = $clog2(DATA_WIDTH + 1);

    alu_fsm_e              state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [OPRN_WIDTH-1:0] oprn_q, oprn_d;
    logic [RemW-1:0]       rem_q, rem_d, rem_init;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  accept, mul_start, mul_busy, mul_done;
    logic [DATA_WIDTH-1:0] mul_product, shift_next, single_res;
    logic                  single_err;

    assign accept    = (state_q == StIdle) && req_valid && req_ready_q;
    assign mul_start = accept && (oprn == OPRN_WIDTH'(OpMul));
    assign rem_init  = (op2 >= DATA_WIDTH'(DATA_WIDTH)) ? RemW'(DATA_WIDTH) : RemW'(op2);

    alu_mul_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .clk_i    (CLK),
        .rst_i    (RST),
        .start_i  (mul_start),
        .mcand_i  (op1),
        .mplier_i (op2),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    assign shift_next = (oprn_q == OPRN_WIDTH'(OpSrl)) ? (a_q >> 1) : (a_q << 1);

    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (oprn_q)
            OPRN_WIDTH'(OpAdd): single_res = a_q + b_q;
            OPRN_WIDTH'(OpSub): single_res = a_q - b_q;
            OPRN_WIDTH'(OpAnd): single_res = a_q & b_q;
            OPRN_WIDTH'(OpOr):  single_res = a_q | b_q;
            OPRN_WIDTH'(OpNor): single_res = ~(a_q | b_q);
            OPRN_WIDTH'(OpSlt): single_res = {{(DATA_WIDTH - 1){1'b0}}, (a_q < b_q)};
            default:            single_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        oprn_d      = oprn_q;
        rem_d       = rem_q;
        result_d    = result_q;
        rsp_err_d   = rsp_err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d         = op1;
                    b_d         = op2;
                    oprn_d      = oprn;
                    rem_d       = rem_init;
                    req_ready_d = 1'b0;
                    state_d     = StExec;
                end
            end
            StExec: begin
                if (oprn_q == OPRN_WIDTH'(OpMul)) begin
                    if (mul_busy && mul_done) begin
                        result_d    = mul_product;
                        rsp_err_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end else if (op_is_shift(32'(oprn_q))) begin
                    // A zero shift amount still spends one clock and returns op1.
                    if (rem_q == '0) begin
                        result_d    = a_q;
                        rsp_err_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        a_d   = shift_next;
                        rem_d = rem_q - 1'b1;
                        if (rem_q == RemW'(1)) begin
                            result_d    = shift_next;
                            rsp_err_d   = 1'b0;
                            rsp_valid_d = 1'b1;
                            state_d     = StDone;
                        end
                    end
                end else begin
                    result_d    = single_res;
                    rsp_err_d   = single_err;
                    rsp_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            oprn_q      <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            oprn_q      <= oprn_d;
            rem_q       <= rem_d;
            result_q    <= result_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign result    = result_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_mc_responder.sv
// Randomized and directed bench for alu_mc_responder against an arithmetic reference model.
module tb_alu_mc_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op1, op2;
    logic [5:0]  oprn;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_mc_responder #(
        .DATA_WIDTH(32),
        .OPRN_WIDTH(6)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .op1      (op1),
        .op2      (op2),
        .oprn     (oprn),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .result   (result),
        .rsp_err  (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {err, result}.
    function automatic logic [32:0] ref_alu(input int unsigned op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            1: r = a + b;
            2: r = a - b;
            3: r = a * b;
            4: r = (b >= 32) ? 32'd0 : (a >> b);
            5: r = (b >= 32) ? 32'd0 : (a << b);
            6: r = a & b;
            7: r = a | b;
            8: r = ~(a | b);
            9: r = (a < b) ? 32'd1 : 32'd0;
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic int exec_clocks(input int unsigned op, input logic [31:0] b);
        if (op == 3) return 32;
        if (op == 4 || op == 5) begin
            if (b == 0) return 1;
            return (b > 32) ? 32 : int'(b);
        end
        return 1;
    endfunction

    // Called at a negedge; returns at a negedge with the unit idle again.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit overlap);
        logic [32:0] exp;
        int          k;
        int          budget;
        exp = ref_alu(op, a, b);
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        op1       = a;
        op2       = b;
        oprn      = op;
        rsp_ready = (stall == 0);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                req_valid = 1'b0;
                op1       = $urandom;
                op2       = $urandom;
                oprn      = 6'($urandom);
            end
        end while (!rsp_valid && k < 100);
        check_eq($sformatf("latency op%0h", op), k, exec_clocks(op, b) + 1);
        check_eq($sformatf("result op%0h a=%0h b=%0h", op, a, b), result, exp[31:0]);
        check_eq($sformatf("rsp_err op%0h", op), rsp_err, exp[32]);
        check_eq("req_ready_busy", req_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_result", result, exp[31:0]);
            check_eq("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        if (overlap) begin
            req_valid = 1'b1;
            op1       = 32'd7;
            op2       = 32'd7;
            oprn      = 6'h01;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check_eq("rsp_valid_dropped", rsp_valid, 0);
        check_eq("req_ready_back", req_ready, 1);
    endtask

    initial begin
        logic [5:0]  rop;
        logic [31:0] ra, rb;
        bit          seen;

        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        op1       = '0;
        op2       = '0;
        oprn      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(6'h01, 32'd15, 32'd3, 0, 0);
        run_op(6'h02, 32'd15, 32'd5, 0, 0);
        run_op(6'h02, 32'd0, 32'd1, 0, 0);
        run_op(6'h03, 32'd5, 32'd10, 0, 0);
        run_op(6'h03, 32'h0001_0000, 32'h0001_0000, 0, 0);
        run_op(6'h04, 32'd4, 32'd1, 0, 0);
        run_op(6'h05, 32'd1, 32'd0, 0, 0);
        run_op(6'h05, 32'd1, 32'd31, 0, 0);
        run_op(6'h04, 32'hDEAD_BEEF, 32'd40, 0, 0);
        run_op(6'h06, 32'd4, 32'd5, 0, 0);
        run_op(6'h07, 32'd12, 32'd3, 0, 0);
        run_op(6'h08, 32'd15, 32'd0, 0, 0);
        run_op(6'h09, 32'd3, 32'd9, 0, 0);
        run_op(6'h09, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_op(6'h0A, 32'd3, 32'd9, 0, 0);
        run_op(6'h00, 32'd3, 32'd9, 0, 0);
        run_op(6'h03, 32'h1234_5678, 32'h9ABC_DEF1, 10, 0);
        run_op(6'h01, 32'd20, 32'd22, 2, 1);

        // Reset in the middle of a multiply must abandon it silently.
        req_valid = 1'b1;
        op1       = 32'd9;
        op2       = 32'd9;
        oprn      = 6'h03;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_req_ready", req_ready, 1);
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_result", result, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        check_eq("midrst_no_rsp", seen, 0);
        rsp_ready = 1'b0;
        run_op(6'h01, 32'd1, 32'd1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 10));
            ra  = $urandom;
            rb  = (rop == 6'h04 || rop == 6'h05) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
